// File: rtl/user_pulse_seq_pkg.sv
// Shared types and the phase-search helper for the user pulse sequencer.
package user_pulse_seq_pkg;

  localparam int MAX_PHASES = 32;
  localparam int IDX_W      = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic             found;
    logic [IDX_W-1:0] idx;
  } phase_sel_t;

  // Lowest enabled index above cur (or at cur when incl is set).
  function automatic phase_sel_t next_phase(input logic [MAX_PHASES-1:0] mask,
                                            input logic [IDX_W-1:0]      cur,
                                            input logic                  incl);
    phase_sel_t r;
    r.found = 1'b0;
    r.idx   = '0;
    for (int i = 0; i < MAX_PHASES; i++) begin
      if (!r.found && mask[i] && ((i > int'(cur)) || (incl && (i == int'(cur))))) begin
        r.found = 1'b1;
        r.idx   = IDX_W'(i);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/user_pulse_seq_phase_timer.sv
// Cycle and repeat counters for the active phase, with end-of-phase and output-level decode.
module user_pulse_seq_phase_timer #(
  parameter int PER_W = 16,
  parameter int REP_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             load,
  input  logic             run,
  input  logic [PER_W-1:0] period,
  input  logic [PER_W-1:0] high,
  input  logic [REP_W-1:0] reps,
  input  logic             inv,
  output logic             phase_end,
  output logic             level,
  output logic [REP_W-1:0] rep
);

  logic [PER_W-1:0] cnt;
  logic             cnt_end;
  logic             rep_end;

  // Only enabled phases run, so period and reps are nonzero whenever these matter.
  assign cnt_end   = (cnt == (period - PER_W'(1)));
  assign rep_end   = (rep == (reps - REP_W'(1)));
  assign phase_end = run && cnt_end && rep_end;
  assign level     = (cnt < high) ^ inv;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= '0;
      rep <= '0;
    end else if (load) begin
      cnt <= '0;
      rep <= '0;
    end else if (run) begin
      if (cnt_end) begin
        cnt <= '0;
        rep <= rep + REP_W'(1);
      end else begin
        cnt <= cnt + PER_W'(1);
      end
    end
  end

endmodule

// File: rtl/user_pulse_sequencer.sv
// Plays up to NUM_PHASES programmable pulse trains back-to-back from a start-time config snapshot.
// Optional USER_PULSE_SEQ_LOOP_EN adds loops_i/loop_o for repeated or endless sequence playback.
module user_pulse_sequencer
  import user_pulse_seq_pkg::*;
#(
  parameter  int NUM_PHASES = 4,
  parameter  int PER_W      = 16,
  parameter  int REP_W      = 8,
  localparam int PH_W       = (NUM_PHASES > 1) ? $clog2(NUM_PHASES) : 1
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        start_i,
  input  logic                        stop_i,
  input  logic [NUM_PHASES*PER_W-1:0] period_i,
  input  logic [NUM_PHASES*PER_W-1:0] high_i,
  input  logic [NUM_PHASES*REP_W-1:0] reps_i,
  input  logic [NUM_PHASES-1:0]       inv_i,
`ifdef USER_PULSE_SEQ_LOOP_EN
  input  logic [7:0]                  loops_i,
  output logic [7:0]                  loop_o,
`endif
  output logic                        pulse_o,
  output logic                        busy_o,
  output logic                        done_o,
  output logic [PH_W-1:0]             phase_o,
  output logic [REP_W-1:0]            rep_o
);

  state_t           state;
  logic [PH_W-1:0]  ph;
  logic             done;
  logic [PER_W-1:0] per_s  [NUM_PHASES];
  logic [PER_W-1:0] high_s [NUM_PHASES];
  logic [REP_W-1:0] reps_s [NUM_PHASES];
  logic [NUM_PHASES-1:0] inv_s;

  logic [MAX_PHASES-1:0] en_in;
  logic [MAX_PHASES-1:0] en_s;
  logic [IDX_W-1:0]      ph_ext;
  phase_sel_t            sel_start;
  phase_sel_t            sel_adv;
  phase_sel_t            sel_first;

  logic start_ok;
  logic phase_end;
  logic level;
  logic restart;
  logic timer_load;

  always_comb begin
    en_in  = '0;
    en_s   = '0;
    ph_ext = '0;
    for (int i = 0; i < NUM_PHASES; i++) begin
      en_in[i] = (reps_i[i*REP_W +: REP_W] != '0) && (period_i[i*PER_W +: PER_W] != '0);
      en_s[i]  = (reps_s[i] != '0) && (per_s[i] != '0);
    end
    ph_ext[PH_W-1:0] = ph;
  end

  assign sel_start = next_phase(en_in, '0, 1'b1);
  assign sel_adv   = next_phase(en_s, ph_ext, 1'b0);
  assign sel_first = next_phase(en_s, '0, 1'b1);

  assign start_ok   = (state == ST_IDLE) && start_i && !stop_i;
  assign timer_load = (start_ok && sel_start.found) ||
                      ((state == ST_RUN) && phase_end && (sel_adv.found || restart));

`ifdef USER_PULSE_SEQ_LOOP_EN
  logic [7:0] loops_s;
  logic [7:0] loop_cnt;

  // loops_s == 0 plays forever; otherwise stop after loops_s completed passes.
  assign restart = (state == ST_RUN) && phase_end && !sel_adv.found &&
                   ((loops_s == 8'd0) || ((loop_cnt + 8'd1) != loops_s));
  assign loop_o  = loop_cnt;

  always_ff @(posedge clk_i) begin
    if (rst_i || stop_i) begin
      loops_s  <= '0;
      loop_cnt <= '0;
    end else if (start_ok) begin
      loops_s  <= loops_i;
      loop_cnt <= '0;
    end else if ((state == ST_RUN) && phase_end && !sel_adv.found && (loop_cnt != 8'hFF)) begin
      loop_cnt <= loop_cnt + 8'd1;
    end
  end
`else
  assign restart = 1'b0;
`endif

  user_pulse_seq_phase_timer #(
    .PER_W (PER_W),
    .REP_W (REP_W)
  ) u_timer (
    .clk       (clk_i),
    .rst       (rst_i),
    .clear     (stop_i),
    .load      (timer_load),
    .run       (state == ST_RUN),
    .period    (per_s[ph]),
    .high      (high_s[ph]),
    .reps      (reps_s[ph]),
    .inv       (inv_s[ph]),
    .phase_end (phase_end),
    .level     (level),
    .rep       (rep_o)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= ST_IDLE;
      ph    <= '0;
      done  <= 1'b0;
      inv_s <= '0;
      for (int i = 0; i < NUM_PHASES; i++) begin
        per_s[i]  <= '0;
        high_s[i] <= '0;
        reps_s[i] <= '0;
      end
    end else begin
      done <= 1'b0;
      if (stop_i) begin
        state <= ST_IDLE;
        ph    <= '0;
      end else begin
        unique case (state)
          ST_IDLE: begin
            if (start_i) begin
              inv_s <= inv_i;
              for (int i = 0; i < NUM_PHASES; i++) begin
                per_s[i]  <= period_i[i*PER_W +: PER_W];
                high_s[i] <= high_i[i*PER_W +: PER_W];
                reps_s[i] <= reps_i[i*REP_W +: REP_W];
              end
              if (sel_start.found) begin
                state <= ST_RUN;
                ph    <= PH_W'(sel_start.idx);
              end else begin
                state <= ST_DONE;
                done  <= 1'b1;
              end
            end
          end
          ST_RUN: begin
            if (phase_end) begin
              if (sel_adv.found) begin
                ph <= PH_W'(sel_adv.idx);
              end else if (restart) begin
                ph <= PH_W'(sel_first.idx);
              end else begin
                state <= ST_DONE;
                done  <= 1'b1;
              end
            end
          end
          ST_DONE: state <= ST_IDLE;
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  // Output level is decoded from registered state only.
  assign pulse_o = (state == ST_RUN) && level;
  assign busy_o  = (state == ST_RUN);
  assign done_o  = done;
  assign phase_o = ph;

endmodule

// File: tb/tb_user_pulse_sequencer.sv
// Directed self-checking bench for user_pulse_sequencer (loop tests only with USER_PULSE_SEQ_LOOP_EN).
module tb_user_pulse_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        stop;
  logic [63:0] period;
  logic [63:0] high;
  logic [31:0] reps;
  logic [3:0]  inv;
  logic        pulse;
  logic        busy;
  logic        done;
  logic [1:0]  phase;
  logic [7:0]  rep;
`ifdef USER_PULSE_SEQ_LOOP_EN
  logic [7:0]  loops;
  logic [7:0]  loop;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  user_pulse_sequencer #(
    .NUM_PHASES (4),
    .PER_W      (16),
    .REP_W      (8)
  ) dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .start_i  (start),
    .stop_i   (stop),
    .period_i (period),
    .high_i   (high),
    .reps_i   (reps),
    .inv_i    (inv),
`ifdef USER_PULSE_SEQ_LOOP_EN
    .loops_i  (loops),
    .loop_o   (loop),
`endif
    .pulse_o  (pulse),
    .busy_o   (busy),
    .done_o   (done),
    .phase_o  (phase),
    .rep_o    (rep)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_cfg();
    period = '0;
    high   = '0;
    reps   = '0;
    inv    = '0;
  endtask

  task automatic set_phase(input int idx, input int per, input int hi, input int rp, input logic iv);
    period[idx*16 +: 16] = 16'(per);
    high[idx*16 +: 16]   = 16'(hi);
    reps[idx*8 +: 8]     = 8'(rp);
    inv[idx]             = iv;
  endtask

  task automatic two_phase_cfg();
    clear_cfg();
    set_phase(0, 4, 1, 3, 1'b0);
    set_phase(1, 2, 1, 2, 1'b0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) begin
      tick();
      n_assert++;
      if ({pulse, busy, done, phase, rep} !== 13'd0) begin
        n_fail++;
        $display("FAIL reset_outputs: got %b, want 0", {pulse, busy, done, phase, rep});
      end
    end
    rst = 1'b0;
    repeat (5) begin
      tick();
      n_assert++;
      if ({pulse, busy, done, phase} !== 5'd0) begin
        n_fail++;
        $display("FAIL idle_outputs: got %b, want 0", {pulse, busy, done, phase});
      end
    end
  endtask

  task automatic test_two_phase();
    logic [15:0] exp;
    exp = 16'b1000_1000_1000_1010;
    two_phase_cfg();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      n_assert++;
      if (pulse !== exp[15-i] || busy !== 1'b1 || done !== 1'b0) begin
        n_fail++;
        $display("FAIL two_phase_wave cycle %0d: pulse=%b busy=%b done=%b, want pulse=%b busy=1 done=0",
                 i + 1, pulse, busy, done, exp[15-i]);
      end
      n_assert++;
      if (phase !== ((i < 12) ? 2'd0 : 2'd1) || rep !== ((i < 12) ? 8'(i / 4) : 8'((i - 12) / 2))) begin
        n_fail++;
        $display("FAIL two_phase_idx cycle %0d: phase=%0d rep=%0d", i + 1, phase, rep);
      end
      tick();
    end
    n_assert++;
    if (done !== 1'b1 || busy !== 1'b0 || pulse !== 1'b0) begin
      n_fail++;
      $display("FAIL two_phase_done: done=%b busy=%b pulse=%b, want 1 0 0", done, busy, pulse);
    end
    tick();
    n_assert++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL two_phase_idle: done=%b busy=%b, want 0 0", done, busy);
    end
  endtask

  task automatic test_skip_invert();
    logic [5:0] exp;
    exp = 6'b011_011;
    clear_cfg();
    set_phase(0, 5, 2, 0, 1'b0);
    set_phase(2, 3, 1, 2, 1'b1);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      n_assert++;
      if (pulse !== exp[5-i] || phase !== 2'd2 || busy !== 1'b1) begin
        n_fail++;
        $display("FAIL skip_invert cycle %0d: pulse=%b phase=%0d busy=%b, want pulse=%b phase=2 busy=1",
                 i + 1, pulse, phase, busy, exp[5-i]);
      end
      tick();
    end
    n_assert++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL skip_invert_done: done=%b busy=%b, want 1 0", done, busy);
    end
    tick();
  endtask

  task automatic test_edge_fields();
    clear_cfg();
    set_phase(0, 3, 0, 2, 1'b0);
    set_phase(1, 3, 3, 1, 1'b0);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 9; i++) begin
      n_assert++;
      if (pulse !== ((i < 6) ? 1'b0 : 1'b1) || busy !== 1'b1 || done !== 1'b0) begin
        n_fail++;
        $display("FAIL edge_wave cycle %0d: pulse=%b busy=%b done=%b, want pulse=%b busy=1 done=0",
                 i + 1, pulse, busy, done, (i >= 6));
      end
      start = (i == 3);
      tick();
    end
    start = 1'b0;
    n_assert++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL edge_done: done=%b busy=%b, want 1 0", done, busy);
    end
    tick();
    // Nothing enabled: zero reps or zero period everywhere.
    clear_cfg();
    set_phase(0, 4, 1, 0, 1'b0);
    set_phase(1, 0, 0, 5, 1'b1);
    set_phase(3, 2, 1, 0, 1'b0);
    start = 1'b1;
    tick();
    start = 1'b0;
    n_assert++;
    if (done !== 1'b1 || busy !== 1'b0 || pulse !== 1'b0) begin
      n_fail++;
      $display("FAIL empty_done: done=%b busy=%b pulse=%b, want 1 0 0", done, busy, pulse);
    end
    tick();
    n_assert++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL empty_idle: done=%b busy=%b, want 0 0", done, busy);
    end
  endtask

  task automatic test_abort();
    logic [15:0] exp;
    exp = 16'b1000_1000_1000_1010;
    two_phase_cfg();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (12) tick();
    n_assert++;
    if (phase !== 2'd1 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_pre: phase=%0d busy=%b, want 1 1", phase, busy);
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    n_assert++;
    if ({pulse, busy, done, phase, rep} !== 13'd0) begin
      n_fail++;
      $display("FAIL abort_idle: got %b, want 0", {pulse, busy, done, phase, rep});
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      n_assert++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL abort_nodone: done=%b busy=%b, want 0 0", done, busy);
      end
    end
    start = 1'b1;
    stop  = 1'b1;
    tick();
    start = 1'b0;
    stop  = 1'b0;
    for (int i = 0; i < 2; i++) begin
      n_assert++;
      if (busy !== 1'b0 || done !== 1'b0 || pulse !== 1'b0) begin
        n_fail++;
        $display("FAIL start_stop: busy=%b done=%b pulse=%b, want 0 0 0", busy, done, pulse);
      end
      tick();
    end
    // Reprogramming during RUN must not disturb the snapshot.
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      n_assert++;
      if (pulse !== exp[15-i] || busy !== 1'b1) begin
        n_fail++;
        $display("FAIL reprogram_wave cycle %0d: pulse=%b busy=%b, want pulse=%b busy=1",
                 i + 1, pulse, busy, exp[15-i]);
      end
      if (i == 2) begin
        set_phase(0, 7, 5, 1, 1'b1);
        set_phase(1, 9, 0, 4, 1'b0);
      end
      tick();
    end
    n_assert++;
    if (done !== 1'b1) begin
      n_fail++;
      $display("FAIL reprogram_done: done=%b, want 1", done);
    end
    tick();
  endtask

`ifdef USER_PULSE_SEQ_LOOP_EN
  task automatic test_loops();
    logic [3:0] exp;
    exp = 4'b1100;
    clear_cfg();
    set_phase(0, 4, 2, 1, 1'b0);
    loops = 8'd3;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 12; i++) begin
      n_assert++;
      if (pulse !== exp[3 - (i % 4)] || busy !== 1'b1 || done !== 1'b0 || loop !== 8'(i / 4)) begin
        n_fail++;
        $display("FAIL loop3 cycle %0d: pulse=%b busy=%b done=%b loop=%0d, want pulse=%b loop=%0d",
                 i + 1, pulse, busy, done, loop, exp[3 - (i % 4)], i / 4);
      end
      tick();
    end
    n_assert++;
    if (done !== 1'b1 || busy !== 1'b0 || loop !== 8'd3) begin
      n_fail++;
      $display("FAIL loop3_done: done=%b busy=%b loop=%0d, want 1 0 3", done, busy, loop);
    end
    tick();
    loops = 8'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (400) tick();
    n_assert++;
    if (loop !== 8'd100 || busy !== 1'b1 || pulse !== 1'b1) begin
      n_fail++;
      $display("FAIL loop_inf: loop=%0d busy=%b pulse=%b, want 100 1 1", loop, busy, pulse);
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    n_assert++;
    if (busy !== 1'b0 || done !== 1'b0 || loop !== 8'd0) begin
      n_fail++;
      $display("FAIL loop_stop: busy=%b done=%b loop=%0d, want 0 0 0", busy, done, loop);
    end
    loops = 8'd1;
  endtask
`endif

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    stop  = 1'b0;
`ifdef USER_PULSE_SEQ_LOOP_EN
    loops = 8'd1;
`endif
    clear_cfg();
    test_reset();
    test_two_phase();
    test_skip_invert();
    test_edge_fields();
    test_abort();
`ifdef USER_PULSE_SEQ_LOOP_EN
    test_loops();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/user_pulse_sequencer.md
Name: user_pulse_sequencer

Overview:
- Parametrised successor of the user-domain pulser: plays up to NUM_PHASES programmable pulse trains back-to-back on one output.
- Each phase has its own period, high time, repeat count and polarity.
- Configuration is snapshotted at start, so registers may be reprogrammed while a sequence is running.
- Sits in the user domain behind a register-file front end.

Parameters:
- NUM_PHASES, 4, number of phase slots (>=1)
- PER_W, 16, width of period/high-time fields and the cycle counter
- REP_W, 8, width of per-phase repeat count
- PH_W, $clog2(NUM_PHASES) (min 1), phase index width (derived, localparam)

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- start_i  in  1  start request; accepted only in IDLE
- stop_i  in  1  abort; wins over everything
- period_i  in  NUM_PHASES*PER_W  per-phase period in cycles
- high_i  in  NUM_PHASES*PER_W  per-phase high time in cycles
- reps_i  in  NUM_PHASES*REP_W  per-phase pulse count
- inv_i  in  NUM_PHASES  per-phase output inversion
- pulse_o  out  1  pulse output
- busy_o  out  1  high in RUN
- done_o  out  1  one-cycle pulse on normal completion
- phase_o  out  PH_W  active phase index
- rep_o  out  REP_W  completed pulses in the current phase

Behaviour:
- Reset, synchronous on rst_i: state=IDLE, all counters and snapshot registers cleared; pulse_o=0, busy_o=0, done_o=0, phase_o=0, rep_o=0.
- States: IDLE, RUN, DONE (2-bit encoding, defined in package).
- Enabled phase: snapshot reps != 0 and period != 0. Disabled phases are skipped.
- IDLE, start_i=1 and stop_i=0 at cycle t:
  - snapshot all config inputs;
  - if any phase is enabled: at t+1 state=RUN, phase = lowest enabled index, cnt=0, rep=0;
  - if no phase is enabled: at t+1 state=DONE.
- RUN, each cycle:
  - pulse_o = ((cnt < high) XOR inv) of the current phase, decoded from registers only (no input paths).
  - high >= period: the phase output is constant active level.
  - high = 0: the phase output is constant inactive level.
  - cnt increments each cycle. At cnt == period-1: cnt<=0 and rep<=rep+1.
  - When rep == reps-1 and cnt == period-1: advance to the next enabled index above the current one, with cnt=0 and rep=0. There are no idle gap cycles between phases.
  - If no enabled phase remains: end of sequence.
- End of sequence: state=DONE for exactly one cycle with done_o=1, then IDLE.
- DONE: pulse_o=0, busy_o=0. Registers hold the last phase_o/rep_o until the next start.
- stop_i=1 in any state: next state is IDLE, counters cleared, no done_o pulse.
  - stop_i and start_i in the same cycle: stop wins.
  - Combined with the register-decoded output, pulse_o=0 from the cycle after stop.
- start_i in RUN or DONE: ignored. Input config changes during RUN have no effect until the next start.
- All counter arithmetic is unsigned, with no wrap inside a phase: cnt < period always holds, and period-1 is computed in PER_W bits only for period != 0.

Optional Feature:
- Macro: USER_PULSE_SEQ_LOOP_EN.
- Defined:
  - adds input loops_i (8 bits), snapshotted at start;
  - 0 = repeat the sequence forever until stop_i;
  - N = play the whole sequence N times;
  - restart goes to the lowest enabled phase with no gap cycle;
  - done_o fires only after the final pass;
  - adds output loop_o (8 bits) = completed passes (saturates at 255 in infinite mode).
- Undefined: ports absent; the sequence plays once.

Decomposition:
- Package user_pulse_seq_pkg holds:
  - state_t enum;
  - function next_phase(enabled mask, current index, include_current) returning found flag + index, used for both start and advance.
- One sub-module, user_pulse_seq_phase_timer:
  - owns cnt/rep counters and the compare logic;
  - outputs phase_end and pulse level;
  - the top-level FSM drives load/clear.

Test Plan:
- Reset and idle:
  - reset held 3 cycles, then released with no start;
  - pulse_o/busy_o/done_o stay 0; phase_o=0.
- Two-phase sequence: phase0 period=4, high=1, reps=3; phase1 period=2, high=1, reps=2; others reps=0; start.
  - pulse_o = 1000 1000 1000 10 10 (16 cycles, from cycle after start);
  - done_o at cycle 17; busy_o high 16 cycles.
- Skip and invert: phase0 reps=0; phase2 period=3, high=1, inv=1, reps=2.
  - phase_o=2 immediately; pulse_o = 011 011; phase1 and phase3 never visited.
- Edge fields and restart guard:
  - high=0 gives constant 0; high=period gives constant 1;
  - all phases disabled gives done_o on the cycle after start with busy_o=0 throughout;
  - start pulsed mid-RUN is ignored.
- Abort:
  - stop_i mid-phase1 gives IDLE next cycle, pulse_o=0, no done_o;
  - start+stop together gives no start;
  - changing period_i mid-RUN does not alter the waveform.
- With USER_PULSE_SEQ_LOOP_EN, 4-cycle single-phase sequence:
  - loops_i=3: pattern repeated 3x, then one done_o;
  - loops_i=0: runs 100 passes with loop_o=100, stop ends it.
